dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencer and two-way arbiter in front of the MEM-stage data memory. Shares the single data-memory port between the CPU MEM stage and a debug/loader port. Inserts a programmable number of SRAM wait states and produces the pipeline freeze for the CPU. Sits between the EXE/MEM pipeline register outputs and the data-memory instance.

## Interface
Parameters:
- WAIT_CYCLES, 0: extra cycles each access spends before completion (0..15).
- MEM_BASE, 1024: byte address of word 0.
- MEM_WORDS, 64: number of 32-bit words in the data memory.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (state clears on a posedge with rst=0).
- cpu_req  in  1  CPU MEM-stage access request (MEM_R_EN | MEM_W_EN from the pipeline).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data (Rm value).
- cpu_ack  out  1  one-cycle completion pulse; cpu_rdata is valid in that cycle.
- cpu_rdata  out  32  read data.
- cpu_err  out  1  asserted with cpu_ack when the address was rejected.
- cpu_freeze  out  1  pipeline hold = cpu_req & ~cpu_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err: same as the cpu_* ports, for the debug/loader port.
- mem_r_en  out  1  to data memory MEM_R_EN.
- mem_w_en  out  1  to data memory MEM_W_EN.
- mem_addr  out  32  to data memory alu_res.
- mem_wdata  out  32  to data memory rm_val.
- mem_rdata  in  32  from data memory data_mem (combinational read).
- cpu_stall_cnt  out  16  saturating count of cycles with cpu_freeze=1.

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: drives the memory for the granted requester; a wait counter `cnt` runs down to 0.
- IDLE transitions:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesters: grant the one not granted last (`last_gnt` register).
  - On grant, load `cnt`=WAIT_CYCLES, latch the grant, and go to ACCESS.
- ACCESS, cnt>0: decrement cnt and stay.
- ACCESS, cnt==0: assert ack to the granted requester, set `last_gnt`=granted, and return to IDLE. No back-to-back grant; one IDLE turnaround cycle always follows.
- Memory drive during ACCESS:
  - mem_addr and mem_wdata are muxed from the granted requester.
  - mem_r_en=1 for a read in every ACCESS cycle.
  - mem_w_en=1 for a write only in the cnt==0 cycle, so the memory sees exactly one negedge write.
  - All mem_* outputs are 0 in IDLE.
- Read data: granted port's rdata = mem_rdata in the ack cycle. Both rdata outputs are 0 at all other times.
- Address check, done at grant:
  - Legal range is MEM_BASE <= addr < MEM_BASE+4*MEM_WORDS, with addr[1:0]==0.
  - An illegal address still runs the full ACCESS sequence but with no mem_r_en/mem_w_en. Ack is asserted with err=1 and rdata=0.
- Abort: if the granted requester drops req while in ACCESS, return to IDLE next edge with no ack and no write. `last_gnt` is unchanged.
- Requesters hold req, we, addr and wdata stable until ack. Changes to these while granted are undefined, except for the abort case above.
- cpu_stall_cnt increments every cycle cpu_freeze=1 and saturates at 16'hFFFF.

## Timing
- Reset values:
  - Registers: state=IDLE, cnt=0, `last_gnt`=DBG (so the CPU wins the first tie), cpu_stall_cnt=0.
  - Outputs: all acks, errs, rdata and mem_* are 0.
- cpu_freeze is purely combinational and is not forced low by reset.
- Latency: request seen in IDLE at cycle 0 → ack in cycle WAIT_CYCLES+1.
  - Minimum period per access is WAIT_CYCLES+2 cycles.
  - With WAIT_CYCLES=0: ack in cycle 1, memory enabled in cycle 1 only.
- Reset asserted mid-ACCESS: next edge returns to IDLE with no ack. A write is not issued unless the cnt==0 cycle had already passed.
- Same-cycle events:
  - A new request arriving in the ack cycle is only sampled in the following IDLE cycle.
  - The losing requester's freeze/wait continues with no extra penalty beyond its turn.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, ACCESS}.
  - requester enum `dmem_src_t` {SRC_CPU, SRC_DBG}.
  - constants DMEM_BASE=1024 and DMEM_WORDS=64, used as parameter defaults.
- One natural sub-module: `dmem_rr_pick`, the combinational 2-way round-robin selector taking req[1:0] and `last_gnt`. The FSM, counter and muxes stay in dmem_arbiter.

## Test plan
- WAIT_CYCLES=2: CPU write 32'hDEADBEEF to 1028, then CPU read 1028.
  - Each access acks in cycle 3.
  - mem_w_en is high in exactly 1 cycle.
  - Read returns 32'hDEADBEEF.
  - cpu_stall_cnt=6.
- WAIT_CYCLES=0: CPU and DBG both request reads of 1024 from reset.
  - CPU is acked first, in cycle 1; DBG is acked in cycle 3.
  - On a second simultaneous pair, DBG wins.
- DBG write to 1020 (below base) and CPU read of 1026 (unaligned):
  - each gets ack+err, rdata=0;
  - mem_r_en and mem_w_en are never asserted.
- WAIT_CYCLES=3: CPU write granted, req dropped in cnt==1.
  - No ack, no mem_w_en, IDLE next cycle.
  - Reading the address back returns the old value.
- rst=0 pulsed in cycle 2 of a WAIT_CYCLES=3 access:
  - state returns to IDLE, no ack;
  - all outputs 0 except cpu_freeze;
  - cpu_stall_cnt=0.
- CPU held frozen for 70000 cycles (DBG hogging via repeated requests): cpu_stall_cnt saturates at 65535.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   dmem_state_t : arbiter sequencer state (IDLE / ACCESS)
//   dmem_src_t   : requester identity (SRC_CPU / SRC_DBG)
//   DMEM_BASE    : default byte address of data-memory word 0
//   DMEM_WORDS   : default number of 32-bit words in the data memory
//   addr_legal() : range + word-alignment check applied at grant time
package dmem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_state_t;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DBG = 1'b1
    } dmem_src_t;

    localparam int DMEM_BASE  = 1024;
    localparam int DMEM_WORDS = 64;

    // Width of the wait-state counter; WAIT_CYCLES is limited to 0..15.
    localparam int CNT_W = 4;

    // lo is inclusive, hi is exclusive.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr >= lo) && (addr < hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: every bus-level signal around the data-memory arbiter.
//   cpu_* : CPU MEM-stage requester (req/we/addr/wdata in, ack/rdata/err/freeze out)
//   dbg_* : debug/loader requester (req/we/addr/wdata in, ack/rdata/err out)
//   mem_* : data-memory side (r_en/w_en/addr/wdata out, rdata in)
//   cpu_stall_cnt : saturating count of CPU freeze cycles
//
// Handshake: a requester raises req with we/addr/wdata and holds all four
// stable until it sees ack, a single-cycle pulse. rdata and err are valid
// only in the ack cycle. Dropping req before ack abandons the access with
// no ack and no memory write.
//
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        cpu_freeze;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_err;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [15:0] cpu_stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err, cpu_freeze,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_err,
        output mem_r_en, mem_w_en, mem_addr, mem_wdata,
        input  mem_rdata,
        output cpu_stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err, cpu_freeze,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_err,
        input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
        output mem_rdata,
        input  cpu_stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin selector.
//   req[0]   : CPU request
//   req[1]   : debug request
//   last_gnt : requester that completed the most recent access
//   valid    : at least one request present
//   pick     : chosen requester (the one not served last on a tie)
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  dmem_src_t  last_gnt,
    output logic       valid,
    output dmem_src_t  pick
);

    always_comb begin
        valid = |req;
        pick  = SRC_CPU;
        if (req == 2'b11) begin
            pick = (last_gnt == SRC_CPU) ? SRC_DBG : SRC_CPU;
        end else if (req[1]) begin
            pick = SRC_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequencer and two-way arbiter in front of the MEM-stage data
// memory. Shares the single memory port between the CPU and a debug/loader
// port, inserts WAIT_CYCLES wait states per access and generates the CPU
// pipeline freeze.
//   clk       : clock, all state on posedge
//   rst       : synchronous active-low reset
//   bus       : requester / memory signals (dmem_arbiter_if.slave)
//   fsm_state : current sequencer state, for observation
// Parameters: WAIT_CYCLES (0..15), MEM_BASE (byte address of word 0),
// MEM_WORDS (number of 32-bit words).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_BASE    = DMEM_BASE,
    parameter int MEM_WORDS   = DMEM_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus,
    output dmem_state_t  fsm_state
);

    localparam logic [31:0]      ADDR_LO = 32'(MEM_BASE);
    localparam logic [31:0]      ADDR_HI = 32'(MEM_BASE + 4 * MEM_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    dmem_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt;
    dmem_src_t        gnt;
    logic             gnt_ok;
    dmem_src_t        last_gnt;
    logic [15:0]      stall_q;

    logic             pick_valid;
    dmem_src_t        pick_src;
    logic [31:0]      pick_addr;

    logic             sel_req;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             in_acc;
    logic             done;
    logic             cpu_ack_w;
    logic             cpu_freeze_w;

    dmem_rr_pick u_pick (
        .req      ({bus.dbg_req, bus.cpu_req}),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .pick     (pick_src)
    );

    assign pick_addr = (pick_src == SRC_CPU) ? bus.cpu_addr : bus.dbg_addr;

    // Signals of whichever requester currently owns the memory.
    assign sel_req   = (gnt == SRC_CPU) ? bus.cpu_req   : bus.dbg_req;
    assign sel_we    = (gnt == SRC_CPU) ? bus.cpu_we    : bus.dbg_we;
    assign sel_addr  = (gnt == SRC_CPU) ? bus.cpu_addr  : bus.dbg_addr;
    assign sel_wdata = (gnt == SRC_CPU) ? bus.cpu_wdata : bus.dbg_wdata;

    // Qualified with rst so a reset cycle never completes or writes.
    assign in_acc = (state == ACCESS) && sel_req && rst;
    assign done   = in_acc && (cnt == '0);

    assign cpu_ack_w    = done && (gnt == SRC_CPU);
    assign cpu_freeze_w = bus.cpu_req && !cpu_ack_w;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. ACCESS always falls back to IDLE, so every access is
    // followed by one turnaround cycle in which requests are re-arbitrated.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (!sel_req || (cnt == '0)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant, wait counter and round-robin history. last_gnt moves only on a
    // completed access, so an aborted access does not cost its owner a turn.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            gnt      <= SRC_CPU;
            gnt_ok   <= 1'b0;
            last_gnt <= SRC_DBG;
        end else if (state == IDLE) begin
            if (pick_valid) begin
                cnt    <= WAIT_LD;
                gnt    <= pick_src;
                gnt_ok <= addr_legal(pick_addr, ADDR_LO, ADDR_HI);
            end
        end else if (sel_req) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                last_gnt <= gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (cpu_freeze_w && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    // Output logic. Reads are enabled for the whole access; a write is
    // enabled only in the final cycle so the memory sees a single write
    // strobe. Rejected addresses run the full sequence with no enables.
    always_comb begin
        bus.mem_r_en      = in_acc && gnt_ok && !sel_we;
        bus.mem_w_en      = done && gnt_ok && sel_we;
        bus.mem_addr      = in_acc ? sel_addr  : '0;
        bus.mem_wdata     = in_acc ? sel_wdata : '0;

        bus.cpu_ack       = cpu_ack_w;
        bus.cpu_err       = cpu_ack_w && !gnt_ok;
        bus.cpu_rdata     = (cpu_ack_w && gnt_ok) ? bus.mem_rdata : '0;
        bus.cpu_freeze    = cpu_freeze_w;

        bus.dbg_ack       = done && (gnt == SRC_DBG);
        bus.dbg_err       = done && (gnt == SRC_DBG) && !gnt_ok;
        bus.dbg_rdata     = (done && (gnt == SRC_DBG) && gnt_ok) ? bus.mem_rdata : '0;

        bus.cpu_stall_cnt = stall_q;
        fsm_state         = state;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Four instances with WAIT_CYCLES 2, 0, 3 and 15 share
// one clock and reset; each has its own small data-memory model that writes on
// negedge and reads combinationally, initialised to 32'h1000_0000 + word index
// while reset is low.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk;
    logic rst;

    logic [3:0]  cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr [4];
    logic [31:0] cpu_wdata[4];
    logic [31:0] dbg_addr [4];
    logic [31:0] dbg_wdata[4];

    wire  [3:0]  cpu_ack, cpu_err, cpu_freeze, dbg_ack, dbg_err, mem_r_en, mem_w_en;
    wire  [31:0] cpu_rdata[4];
    wire  [31:0] dbg_rdata[4];
    wire  [31:0] mem_addr [4];
    wire  [15:0] stall    [4];
    dmem_state_t fsm_st   [4];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT instances + memory models ----------------
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WC = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 15;

        dmem_arbiter_if bus ();
        logic [31:0] mem [64];
        logic [5:0]  widx;

        assign bus.cpu_req   = cpu_req[g];
        assign bus.cpu_we    = cpu_we[g];
        assign bus.cpu_addr  = cpu_addr[g];
        assign bus.cpu_wdata = cpu_wdata[g];
        assign bus.dbg_req   = dbg_req[g];
        assign bus.dbg_we    = dbg_we[g];
        assign bus.dbg_addr  = dbg_addr[g];
        assign bus.dbg_wdata = dbg_wdata[g];

        assign cpu_ack[g]    = bus.cpu_ack;
        assign cpu_err[g]    = bus.cpu_err;
        assign cpu_freeze[g] = bus.cpu_freeze;
        assign cpu_rdata[g]  = bus.cpu_rdata;
        assign dbg_ack[g]    = bus.dbg_ack;
        assign dbg_err[g]    = bus.dbg_err;
        assign dbg_rdata[g]  = bus.dbg_rdata;
        assign mem_r_en[g]   = bus.mem_r_en;
        assign mem_w_en[g]   = bus.mem_w_en;
        assign mem_addr[g]   = bus.mem_addr;
        assign stall[g]      = bus.cpu_stall_cnt;

        // Base 1024 = 0x400, so bits [7:2] give the word index 0..63.
        assign widx          = bus.mem_addr[7:2];
        assign bus.mem_rdata = mem[widx];

        always @(negedge clk) begin
            if (!rst) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            end else if (bus.mem_w_en) begin
                mem[widx] <= bus.mem_wdata;
            end
        end

        dmem_arbiter #(.WAIT_CYCLES(WC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus.slave),
            .fsm_state (fsm_st[g])
        );
    end

    // ---------------- scoreboard / check ----------------
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called #1 after a posedge while the instance is IDLE (that cycle is
    // cycle 0). Returns #1 after the posedge that ends the ack cycle, or
    // with ack_cyc = -1 if no ack came within the budget.
    task automatic do_access(input int idx, input bit dbg, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int ack_cyc, output logic [31:0] rdata,
                             output logic err, output int ren_n, output int wen_n);
        logic got;
        ack_cyc = -1; rdata = '0; err = 1'b0; ren_n = 0; wen_n = 0;
        if (dbg) begin
            dbg_we[idx] = we; dbg_addr[idx] = addr; dbg_wdata[idx] = wdata; dbg_req[idx] = 1'b1;
        end else begin
            cpu_we[idx] = we; cpu_addr[idx] = addr; cpu_wdata[idx] = wdata; cpu_req[idx] = 1'b1;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_r_en[idx]) ren_n++;
            if (mem_w_en[idx]) wen_n++;
            got = dbg ? dbg_ack[idx] : cpu_ack[idx];
            if (got) begin
                ack_cyc = c;
                rdata   = dbg ? dbg_rdata[idx] : cpu_rdata[idx];
                err     = dbg ? dbg_err[idx]   : cpu_err[idx];
            end
            @(posedge clk); #1;
            if (got) break;
        end
        if (dbg) dbg_req[idx] = 1'b0;
        else     cpu_req[idx] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          ac, rn, wn, n_ack, ncpu, cpu_c0, cpu_c1, dbg_c;
    logic [31:0] rd;
    logic        er, hit_c, hit_d;

    initial begin
        rst = 1'b0;
        cpu_req = '0; cpu_we = '0; dbg_req = '0; dbg_we = '0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr[i] = '0; cpu_wdata[i] = '0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state of every instance.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_state", 32'(fsm_st[i]), 32'(IDLE));
            check("rst_cpu_ack", 32'(cpu_ack[i]), 32'd0);
            check("rst_dbg_ack", 32'(dbg_ack[i]), 32'd0);
            check("rst_mem_en", {30'd0, mem_r_en[i], mem_w_en[i]}, 32'd0);
            check("rst_mem_addr", mem_addr[i], 32'd0);
            check("rst_cpu_rdata", cpu_rdata[i], 32'd0);
            check("rst_stall", 32'(stall[i]), 32'd0);
        end
        @(posedge clk); #1;

        // WAIT_CYCLES=2: write then read back 1028.
        do_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, ac, rd, er, rn, wn);
        check("a_wr_ack_cycle", 32'(ac), 32'd3);
        check("a_wr_wen_cycles", 32'(wn), 32'd1);
        check("a_wr_err", 32'(er), 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        do_access(0, 1'b0, 1'b0, 32'd1028, 32'h0, ac, rd, er, rn, wn);
        check("a_rd_ack_cycle", 32'(ac), 32'd3);
        check("a_rd_data", rd, exp_q.pop_front());
        check("a_rd_ren_cycles", 32'(rn), 32'd3);
        check("a_rd_wen_cycles", 32'(wn), 32'd0);
        @(negedge clk);
        check("a_stall_cnt", 32'(stall[0]), 32'd6);
        @(posedge clk); #1;

        // WAIT_CYCLES=0: simultaneous reads of 1024; the CPU re-requests at
        // once after its first ack, forming a second tie that DBG must win.
        cpu_addr[1] = 32'd1024; dbg_addr[1] = 32'd1024;
        cpu_we[1] = 1'b0; dbg_we[1] = 1'b0;
        cpu_req[1] = 1'b1; dbg_req[1] = 1'b1;
        ncpu = 0; cpu_c0 = -1; cpu_c1 = -1; dbg_c = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hit_c = cpu_ack[1];
            hit_d = dbg_ack[1];
            if (hit_c) begin
                if (ncpu == 0) cpu_c0 = c;
                else           cpu_c1 = c;
                ncpu++;
                check("b_cpu_rdata", cpu_rdata[1], 32'h1000_0000);
            end
            if (hit_d) begin
                dbg_c = c;
                check("b_dbg_rdata", dbg_rdata[1], 32'h1000_0000);
            end
            @(posedge clk); #1;
            if (hit_c && ncpu == 2) cpu_req[1] = 1'b0;
            if (hit_d) dbg_req[1] = 1'b0;
            if (!cpu_req[1] && !dbg_req[1]) break;
        end
        check("b_cpu_first_ack", 32'(cpu_c0), 32'd1);
        check("b_dbg_ack", 32'(dbg_c), 32'd3);
        check("b_cpu_second_ack", 32'(cpu_c1), 32'd5);

        // Address rejection and range boundaries (WAIT_CYCLES=0).
        do_access(1, 1'b1, 1'b1, 32'd1020, 32'h1234_5678, ac, rd, er, rn, wn);
        check("c_dbg_low_ack", 32'(ac), 32'd1);
        check("c_dbg_low_err", 32'(er), 32'd1);
        check("c_dbg_low_rdata", rd, 32'd0);
        check("c_dbg_low_en", 32'(rn + wn), 32'd0);
        do_access(1, 1'b0, 1'b0, 32'd1026, 32'h0, ac, rd, er, rn, wn);
        check("c_cpu_unal_ack", 32'(ac), 32'd1);
        check("c_cpu_unal_err", 32'(er), 32'd1);
        check("c_cpu_unal_rdata", rd, 32'd0);
        check("c_cpu_unal_en", 32'(rn + wn), 32'd0);
        do_access(1, 1'b0, 1'b0, 32'd1280, 32'h0, ac, rd, er, rn, wn);
        check("c_cpu_top_err", 32'(er), 32'd1);
        check("c_cpu_top_en", 32'(rn + wn), 32'd0);
        do_access(1, 1'b0, 1'b0, 32'd1276, 32'h0, ac, rd, er, rn, wn);
        check("c_cpu_last_err", 32'(er), 32'd0);
        check("c_cpu_last_rdata", rd, 32'h1000_003F);

        // WAIT_CYCLES=3: write abandoned while cnt==1 (cycle 3).
        cpu_we[2] = 1'b1; cpu_addr[2] = 32'd1032; cpu_wdata[2] = 32'hCAFE_F00D;
        cpu_req[2] = 1'b1;
        n_ack = 0; wn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_ack += int'(cpu_ack[2]);
            wn    += int'(mem_w_en[2]);
            @(posedge clk); #1;
            if (c == 2) cpu_req[2] = 1'b0;
        end
        @(negedge clk);
        check("d_abort_state", 32'(fsm_st[2]), 32'(IDLE));
        check("d_abort_acks", 32'(n_ack), 32'd0);
        check("d_abort_wen", 32'(wn), 32'd0);
        @(posedge clk); #1;
        do_access(2, 1'b0, 1'b0, 32'd1032, 32'h0, ac, rd, er, rn, wn);
        check("d_readback_ack", 32'(ac), 32'd4);
        check("d_readback_data", rd, 32'h1000_0002);

        // WAIT_CYCLES=3: reset pulsed in cycle 2 of a read; CPU keeps req.
        cpu_we[2] = 1'b0; cpu_addr[2] = 32'd1036; cpu_req[2] = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_ack += int'(cpu_ack[2]);
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            if (c == 2) rst = 1'b1;
        end
        @(negedge clk);
        check("e_rst_acks", 32'(n_ack), 32'd0);
        check("e_rst_state", 32'(fsm_st[2]), 32'(IDLE));
        check("e_rst_cpu_ack", 32'(cpu_ack[2]), 32'd0);
        check("e_rst_mem_en", {30'd0, mem_r_en[2], mem_w_en[2]}, 32'd0);
        check("e_rst_mem_addr", mem_addr[2], 32'd0);
        check("e_rst_rdata_err", {cpu_rdata[2][30:0], cpu_err[2]}, 32'd0);
        check("e_rst_freeze", 32'(cpu_freeze[2]), 32'd1);
        check("e_rst_stall", 32'(stall[2]), 32'd0);
        @(posedge clk); #1;
        cpu_req[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // WAIT_CYCLES=15: both ports request continuously; the CPU is frozen
        // 33 of every 34 cycles, well past 65535 freeze cycles in total.
        cpu_we[3] = 1'b0; dbg_we[3] = 1'b0;
        cpu_addr[3] = 32'd1024; dbg_addr[3] = 32'd1028;
        cpu_req[3] = 1'b1; dbg_req[3] = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("f_stall_saturated", 32'(stall[3]), 32'h0000_FFFF);
        @(posedge clk); #1;
        cpu_req[3] = 1'b0; dbg_req[3] = 1'b0;
        repeat (2) @(posedge clk);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
